flu_wb_arbiter: RTL and testbench
=================================

Name: flu_wb_arbiter

Overview:
- Arbitrates the single fixed-latency-unit (FLU) writeback port into the scoreboard.
- Two requesters share the port:
  - the zero-latency path: ALU / branch / CSR results, which cannot stall;
  - a multi-cycle unit (multiplier/divider), which uses a valid/ready handshake.
- Multi-cycle results that lose arbitration are held in a small FIFO.
- A starvation counter asks the issue stage to pause FLU issue so that buffered results drain.

Parameters:
- XLEN, 64, width of result data.
- TRANS_ID_BITS, 3, width of the scoreboard transaction ID.
- DEPTH, 2, multi-cycle result FIFO entries; power of two, ≥1.
- MAX_WAIT, 4, consecutive lost-arbitration cycles before hold_issue_o asserts; ≥1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active low
- flush_i  in  1  pipeline flush
- single_valid_i  in  1  zero-latency FLU result valid this cycle
- single_result_i  in  XLEN  zero-latency result
- single_trans_id_i  in  TRANS_ID_BITS  zero-latency scoreboard ID
- mc_valid_i  in  1  multi-cycle result valid
- mc_ready_o  out  1  arbiter can accept a multi-cycle result
- mc_result_i  in  XLEN  multi-cycle result
- mc_trans_id_i  in  TRANS_ID_BITS  multi-cycle scoreboard ID
- wb_valid_o  out  1  writeback valid
- wb_result_o  out  XLEN  writeback data
- wb_trans_id_o  out  TRANS_ID_BITS  writeback ID
- wb_src_o  out  1  writeback source: 0 = zero-latency, 1 = multi-cycle (FIFO or bypass)
- hold_issue_o  out  1  issue stage must not issue an FLU op this cycle
- conflict_o  out  1  perf pulse: a multi-cycle result lost arbitration this cycle

Behaviour:
- Reset (async, rst_ni low):
  - FIFO empty; read/write pointers and occupancy 0; starvation counter 0.
  - Outputs: mc_ready_o=1, hold_issue_o=0, wb_valid_o=0, conflict_o=0, wb_src_o=0, wb_result_o=0, wb_trans_id_o=0.
  - Reset mid-operation discards all buffered results.
- mc_ready_o = !full. It is derived from registered occupancy only, with no combinational path from inputs.
- Handshake: a multi-cycle transfer occurs when mc_valid_i && mc_ready_o. The multi-cycle unit holds data stable while mc_valid_i && !mc_ready_o.
- Writeback priority, all combinational, 0-cycle latency:
  1. flush_i: wb_valid_o=0. No push, no pop.
  2. single_valid_i: forward single_*, wb_src_o=0. A transferring mc result is pushed into the FIFO; conflict_o=1 if mc_valid_i.
  3. FIFO non-empty: forward FIFO head, wb_src_o=1, pop. A simultaneous mc transfer is pushed, so occupancy is unchanged.
  4. FIFO empty && mc_valid_i: bypass mc_* directly, wb_src_o=1. No push.
  5. Otherwise: wb_valid_o=0.
- Ordering: multi-cycle results retire in arrival order. Bypass is never taken while the FIFO holds entries.
- Full FIFO: mc_ready_o=0. A pop in the same cycle does not raise mc_ready_o until the next cycle.
- Occupancy:
  - Width is $clog2(DEPTH+1).
  - next = occ + push − pop, where push and pop are exclusive with flush.
  - Pointers wrap modulo DEPTH.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and single_valid_i && !flush_i.
  - Saturates at MAX_WAIT.
  - Clears on any pop, on FIFO empty, or on flush.
- hold_issue_o = (cnt == MAX_WAIT) && !empty. It is driven from registered state only.
  - When hold_issue_o is asserted, the issue stage guarantees single_valid_i=0 that cycle, so the head pops.
  - single_valid_i while hold_issue_o is a protocol violation. It is covered by an assertion; the zero-latency result still wins.
- Flush:
  - FIFO and counter clear at the next edge.
  - mc_valid_i in the flush cycle is dropped.
  - mc_ready_o=1 from the cycle after flush.
- conflict_o = single_valid_i && (mc_valid_i || !empty) && !flush_i.

Test Plan:
- Isolated mc op: FIFO empty, mc_valid_i=1 with trans_id 5 and result 0x2A, single idle → same cycle wb_valid_o=1, wb_trans_id_o=5, wb_result_o=0x2A, wb_src_o=1; occupancy stays 0.
- Collision: single (id 1) and mc (id 2) valid in cycle N → cycle N writes back id 1 with conflict_o=1; cycle N+1 (single idle) writes back id 2 from the FIFO, wb_src_o=1.
- Fill: DEPTH=2; single_valid_i=1 for 3 cycles while mc offers ids 3, 4, 6 → ids 3 and 4 accepted; mc_ready_o=0 from cycle 2; id 6 is held by the source. Later ids 3, 4, 6 retire in order.
- Starvation: MAX_WAIT=4; FIFO holds 1 entry; single_valid_i=1 continuously → hold_issue_o rises after the 4th lost cycle. The bench drops single_valid_i → the head pops that cycle, and hold_issue_o falls next cycle.
- Flush: FIFO holds 2 entries; flush_i=1 with mc_valid_i=1 → wb_valid_o=0 that cycle. Next cycle occupancy is 0, mc_ready_o=1, and no stale ID is ever written back.
- Async reset mid-operation: FIFO full with hold_issue_o=1, rst_ni pulsed low between edges → outputs take their reset values immediately, with no writeback after release.

Source files
------------

// File: rtl/flu_wb_arbiter.sv
// Writeback arbiter for the fixed-latency unit: the zero-latency path always wins,
// while multi-cycle results are bypassed or buffered in a small in-order FIFO.
module flu_wb_arbiter #(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned DEPTH         = 2,
  parameter int unsigned MAX_WAIT      = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     single_valid_i,
  input  logic [XLEN-1:0]          single_result_i,
  input  logic [TRANS_ID_BITS-1:0] single_trans_id_i,
  input  logic                     mc_valid_i,
  output logic                     mc_ready_o,
  input  logic [XLEN-1:0]          mc_result_i,
  input  logic [TRANS_ID_BITS-1:0] mc_trans_id_i,
  output logic                     wb_valid_o,
  output logic [XLEN-1:0]          wb_result_o,
  output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic                     wb_src_o,
  output logic                     hold_issue_o,
  output logic                     conflict_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  logic [XLEN-1:0]          mem_result_q [DEPTH];
  logic [TRANS_ID_BITS-1:0] mem_id_q     [DEPTH];
  logic [PTR_W-1:0]         rd_ptr_q, wr_ptr_q;
  logic [OCC_W-1:0]         occ_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     empty, full, mc_fire, push, pop;

  assign empty        = (occ_q == '0);
  assign full         = (occ_q == OCC_W'(DEPTH));
  assign mc_ready_o   = !full;
  assign mc_fire      = mc_valid_i && mc_ready_o;
  assign hold_issue_o = (cnt_q == CNT_W'(MAX_WAIT)) && !empty;
  assign conflict_o   = rst_ni && single_valid_i && (mc_valid_i || !empty) && !flush_i;

  // Outputs are gated by reset so they read idle as soon as rst_ni drops.
  always_comb begin
    push          = 1'b0;
    pop           = 1'b0;
    wb_valid_o    = 1'b0;
    wb_result_o   = '0;
    wb_trans_id_o = '0;
    wb_src_o      = 1'b0;
    if (rst_ni && !flush_i) begin
      if (single_valid_i) begin
        wb_valid_o    = 1'b1;
        wb_result_o   = single_result_i;
        wb_trans_id_o = single_trans_id_i;
        push          = mc_fire;
      end else if (!empty) begin
        wb_valid_o    = 1'b1;
        wb_result_o   = mem_result_q[rd_ptr_q];
        wb_trans_id_o = mem_id_q[rd_ptr_q];
        wb_src_o      = 1'b1;
        pop           = 1'b1;
        push          = mc_fire;
      end else if (mc_valid_i) begin
        wb_valid_o    = 1'b1;
        wb_result_o   = mc_result_i;
        wb_trans_id_o = mc_trans_id_i;
        wb_src_o      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_result_q[wr_ptr_q] <= mc_result_i;
      mem_id_q[wr_ptr_q]     <= mc_trans_id_i;
    end
  end

  // Starvation counter only runs while a buffered result keeps losing to the single path.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      occ_q <= occ_q + OCC_W'(push) - OCC_W'(pop);
      if (pop || empty) cnt_q <= '0;
      else if (single_valid_i && cnt_q != CNT_W'(MAX_WAIT)) cnt_q <= cnt_q + 1'b1;
    end
  end

  hold_protocol: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(hold_issue_o && single_valid_i));

endmodule

// File: tb/tb_flu_wb_arbiter.sv
// Scoreboard bench for flu_wb_arbiter: expected writebacks are queued when driven
// and matched against DUT writebacks by a monitor sampling on the falling edge.
module tb_flu_wb_arbiter;
  typedef struct packed {
    logic [2:0]  id;
    logic [63:0] res;
  } wb_t;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic        single_valid_i = 1'b0;
  logic [63:0] single_result_i = '0;
  logic [2:0]  single_trans_id_i = '0;
  logic        mc_valid_i = 1'b0;
  logic        mc_ready_o;
  logic [63:0] mc_result_i = '0;
  logic [2:0]  mc_trans_id_i = '0;
  logic        wb_valid_o;
  logic [63:0] wb_result_o;
  logic [2:0]  wb_trans_id_o;
  logic        wb_src_o;
  logic        hold_issue_o;
  logic        conflict_o;

  int  pass_cnt = 0;
  int  total_cnt = 0;
  wb_t single_q[$];
  wb_t mc_q[$];

  flu_wb_arbiter #(.XLEN(64), .TRANS_ID_BITS(3), .DEPTH(2), .MAX_WAIT(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .single_valid_i(single_valid_i), .single_result_i(single_result_i),
    .single_trans_id_i(single_trans_id_i),
    .mc_valid_i(mc_valid_i), .mc_ready_o(mc_ready_o), .mc_result_i(mc_result_i),
    .mc_trans_id_i(mc_trans_id_i),
    .wb_valid_o(wb_valid_o), .wb_result_o(wb_result_o), .wb_trans_id_o(wb_trans_id_o),
    .wb_src_o(wb_src_o), .hold_issue_o(hold_issue_o), .conflict_o(conflict_o)
  );

  always #5 clk_i = ~clk_i;

  // Monitor: every writeback must match the head of the queue for its source.
  always @(negedge clk_i) begin
    if (rst_ni && wb_valid_o) begin
      wb_t exp_e;
      total_cnt++;
      if (wb_src_o == 1'b0 && single_q.size() == 0)
        $display("[TB] FAIL sb_single_unexpected: got id %0d, want no writeback", wb_trans_id_o);
      else if (wb_src_o == 1'b1 && mc_q.size() == 0)
        $display("[TB] FAIL sb_mc_unexpected: got id %0d, want no writeback", wb_trans_id_o);
      else begin
        exp_e = (wb_src_o == 1'b0) ? single_q.pop_front() : mc_q.pop_front();
        if (wb_trans_id_o !== exp_e.id || wb_result_o !== exp_e.res)
          $display("[TB] FAIL sb_match src%0b: got id %0d res %h, want id %0d res %h",
                   wb_src_o, wb_trans_id_o, wb_result_o, exp_e.id, exp_e.res);
        else pass_cnt++;
      end
    end
  end

  // Drives one cycle of inputs just after the rising edge; single results are queued here.
  task automatic drive(input logic sv, input logic [2:0] sid, input logic mv,
                       input logic [2:0] mid, input logic fl);
    @(posedge clk_i);
    #1;
    single_valid_i    = sv;
    single_trans_id_i = sid;
    single_result_i   = 64'h1000 + 64'(sid);
    mc_valid_i        = mv;
    mc_trans_id_i     = mid;
    mc_result_i       = 64'h2000 + 64'(mid);
    flush_i           = fl;
    if (sv && !fl) single_q.push_back('{id: sid, res: 64'h1000 + 64'(sid)});
  endtask

  function automatic wb_t mc_item(input logic [2:0] id);
    return '{id: id, res: 64'h2000 + 64'(id)};
  endfunction

  task automatic test_reset();
    @(negedge clk_i);
    total_cnt++;
    if ({mc_ready_o, hold_issue_o, wb_valid_o, conflict_o, wb_src_o} !== 5'b10000)
      $display("[TB] FAIL reset_flags: got %b, want 10000",
               {mc_ready_o, hold_issue_o, wb_valid_o, conflict_o, wb_src_o});
    else pass_cnt++;
    total_cnt++;
    if (wb_result_o !== 64'd0 || wb_trans_id_o !== 3'd0)
      $display("[TB] FAIL reset_data: got %h/%0d, want 0/0", wb_result_o, wb_trans_id_o);
    else pass_cnt++;
    #2 rst_ni = 1'b1;
  endtask

  task automatic test_bypass();
    drive(0, 0, 1, 3'd5, 0);
    mc_q.push_back('{id: 3'd5, res: 64'h2A});
    mc_result_i = 64'h2A;
    @(negedge clk_i);
    total_cnt++;
    if ({wb_valid_o, wb_src_o, conflict_o, mc_ready_o} !== 4'b1101)
      $display("[TB] FAIL bypass_flags: got %b, want 1101", {wb_valid_o, wb_src_o, conflict_o, mc_ready_o});
    else pass_cnt++;
    drive(0, 0, 0, 0, 0);
    @(negedge clk_i);
    total_cnt++;
    if (wb_valid_o !== 1'b0 || mc_ready_o !== 1'b1)
      $display("[TB] FAIL bypass_no_buffer: got valid %b ready %b, want 0 1", wb_valid_o, mc_ready_o);
    else pass_cnt++;
  endtask

  task automatic test_collision();
    drive(1, 3'd1, 1, 3'd2, 0);
    mc_q.push_back(mc_item(3'd2));
    @(negedge clk_i);
    total_cnt++;
    if ({conflict_o, wb_src_o, wb_trans_id_o} !== {1'b1, 1'b0, 3'd1})
      $display("[TB] FAIL collision_win: got c%b s%b id%0d, want c1 s0 id1", conflict_o, wb_src_o, wb_trans_id_o);
    else pass_cnt++;
    drive(0, 0, 0, 0, 0);
    @(negedge clk_i);
    total_cnt++;
    if ({wb_valid_o, wb_src_o, wb_trans_id_o, conflict_o} !== {1'b1, 1'b1, 3'd2, 1'b0})
      $display("[TB] FAIL collision_drain: got v%b s%b id%0d c%b, want v1 s1 id2 c0",
               wb_valid_o, wb_src_o, wb_trans_id_o, conflict_o);
    else pass_cnt++;
    drive(0, 0, 0, 0, 0);
    @(negedge clk_i);
  endtask

  task automatic test_fill();
    logic [2:0] mids [3] = '{3'd3, 3'd4, 3'd6};
    logic       want_ready [3] = '{1'b1, 1'b1, 1'b0};
    logic [2:0] sids [3] = '{3'd0, 3'd1, 3'd7};
    for (int i = 0; i < 3; i++) begin
      drive(1, sids[i], 1, mids[i], 0);
      if (want_ready[i]) mc_q.push_back(mc_item(mids[i]));
      @(negedge clk_i);
      total_cnt++;
      if (mc_ready_o !== want_ready[i] || conflict_o !== 1'b1)
        $display("[TB] FAIL fill_ready%0d: got r%b c%b, want r%b c1", i, mc_ready_o, conflict_o, want_ready[i]);
      else pass_cnt++;
    end
    drive(0, 0, 1, 3'd6, 0);
    @(negedge clk_i);
    total_cnt++;
    if (mc_ready_o !== 1'b0 || wb_trans_id_o !== 3'd3)
      $display("[TB] FAIL fill_pop_full: got r%b id%0d, want r0 id3", mc_ready_o, wb_trans_id_o);
    else pass_cnt++;
    drive(0, 0, 1, 3'd6, 0);
    mc_q.push_back(mc_item(3'd6));
    @(negedge clk_i);
    total_cnt++;
    if (mc_ready_o !== 1'b1 || wb_trans_id_o !== 3'd4)
      $display("[TB] FAIL fill_accept6: got r%b id%0d, want r1 id4", mc_ready_o, wb_trans_id_o);
    else pass_cnt++;
    drive(0, 0, 0, 0, 0);
    @(negedge clk_i);
    drive(0, 0, 0, 0, 0);
    @(negedge clk_i);
    total_cnt++;
    if (wb_valid_o !== 1'b0)
      $display("[TB] FAIL fill_drained: got valid %b, want 0", wb_valid_o);
    else pass_cnt++;
  endtask

  task automatic test_starvation();
    drive(1, 3'd1, 1, 3'd2, 0);
    mc_q.push_back(mc_item(3'd2));
    for (int k = 0; k < 4; k++) begin
      drive(1, 3'(k + 3), 0, 0, 0);
      @(negedge clk_i);
      total_cnt++;
      if (hold_issue_o !== 1'b0 || conflict_o !== 1'b1)
        $display("[TB] FAIL starve_lost%0d: got h%b c%b, want h0 c1", k, hold_issue_o, conflict_o);
      else pass_cnt++;
    end
    drive(0, 0, 0, 0, 0);
    @(negedge clk_i);
    total_cnt++;
    if (hold_issue_o !== 1'b1 || wb_src_o !== 1'b1 || wb_trans_id_o !== 3'd2)
      $display("[TB] FAIL starve_hold: got h%b s%b id%0d, want h1 s1 id2", hold_issue_o, wb_src_o, wb_trans_id_o);
    else pass_cnt++;
    drive(0, 0, 0, 0, 0);
    @(negedge clk_i);
    total_cnt++;
    if (hold_issue_o !== 1'b0 || wb_valid_o !== 1'b0)
      $display("[TB] FAIL starve_release: got h%b v%b, want h0 v0", hold_issue_o, wb_valid_o);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    drive(1, 3'd1, 1, 3'd3, 0);
    mc_q.push_back(mc_item(3'd3));
    drive(1, 3'd2, 1, 3'd4, 0);
    mc_q.push_back(mc_item(3'd4));
    drive(0, 0, 1, 3'd5, 1);
    @(negedge clk_i);
    total_cnt++;
    if (wb_valid_o !== 1'b0 || conflict_o !== 1'b0 || mc_ready_o !== 1'b0)
      $display("[TB] FAIL flush_cycle: got v%b c%b r%b, want v0 c0 r0", wb_valid_o, conflict_o, mc_ready_o);
    else pass_cnt++;
    mc_q.delete();
    drive(0, 0, 0, 0, 0);
    @(negedge clk_i);
    total_cnt++;
    if (mc_ready_o !== 1'b1 || wb_valid_o !== 1'b0 || hold_issue_o !== 1'b0)
      $display("[TB] FAIL flush_after: got r%b v%b h%b, want r1 v0 h0", mc_ready_o, wb_valid_o, hold_issue_o);
    else pass_cnt++;
    drive(0, 0, 1, 3'd6, 0);
    mc_q.push_back(mc_item(3'd6));
    @(negedge clk_i);
    total_cnt++;
    if (wb_trans_id_o !== 3'd6 || wb_src_o !== 1'b1)
      $display("[TB] FAIL flush_bypass: got id%0d s%b, want id6 s1", wb_trans_id_o, wb_src_o);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    drive(1, 3'd0, 1, 3'd3, 0);
    mc_q.push_back(mc_item(3'd3));
    drive(1, 3'd1, 1, 3'd4, 0);
    mc_q.push_back(mc_item(3'd4));
    for (int k = 0; k < 3; k++) drive(1, 3'(k + 5), 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    @(negedge clk_i);
    total_cnt++;
    if (hold_issue_o !== 1'b1 || mc_ready_o !== 1'b0)
      $display("[TB] FAIL rmid_setup: got h%b r%b, want h1 r0", hold_issue_o, mc_ready_o);
    else pass_cnt++;
    #1 rst_ni = 1'b0;
    single_valid_i = 1'b1;
    single_trans_id_i = 3'd7;
    mc_q.delete();
    #1;
    total_cnt++;
    if ({wb_valid_o, hold_issue_o, mc_ready_o, conflict_o, wb_src_o} !== 5'b00100 ||
        wb_result_o !== 64'd0 || wb_trans_id_o !== 3'd0)
      $display("[TB] FAIL rmid_async: got v%b h%b r%b c%b s%b res %h id%0d, want 0 0 1 0 0 0 0",
               wb_valid_o, hold_issue_o, mc_ready_o, conflict_o, wb_src_o, wb_result_o, wb_trans_id_o);
    else pass_cnt++;
    single_valid_i = 1'b0;
    #1 rst_ni = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 0);
      @(negedge clk_i);
      total_cnt++;
      if (wb_valid_o !== 1'b0 || mc_ready_o !== 1'b1)
        $display("[TB] FAIL rmid_after%0d: got v%b r%b, want v0 r1", k, wb_valid_o, mc_ready_o);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_collision();
    test_fill();
    test_starvation();
    test_flush();
    test_reset_mid();
    drive(0, 0, 0, 0, 0);
    @(negedge clk_i);
    total_cnt++;
    if (single_q.size() != 0 || mc_q.size() != 0)
      $display("[TB] FAIL sb_leftover: got %0d single %0d mc pending, want 0 0", single_q.size(), mc_q.size());
    else pass_cnt++;
    $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
